regfile_sb: RTL and testbench

//  Parametrised successor of the core register file: 2 async read ports, 1 sync write port.

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file.
// Master is the pipeline side, slave is the register file.
interface regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rv1;
    logic [DATA_W-1:0] rv2;
    logic              busy1;
    logic              busy2;
    logic              we_reg;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] indata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              ready;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output rs1, rs2, we_reg, rd, indata, iss_valid, iss_rd,
        input  rv1, rv2, busy1, busy2, ready, dbg_data
    );

    modport slave (
        input  rs1, rs2, we_reg, rd, indata, iss_valid, iss_rd,
        output rv1, rv2, busy1, busy2, ready, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero r0, write-to-read bypass, per-register
// busy scoreboard and a one-register-per-cycle clear sweep after reset.

// One read port: r0/not-ready masking and same-cycle writeback bypass.
module regfile_sb_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              run,
    input  logic              we_hit,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] indata,
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_busy,
    output logic [DATA_W-1:0] rv,
    output logic              busy
);
    logic zero;
    logic bypass;

    assign zero   = !run || (rs == '0);
    assign bypass = we_hit && (rd == rs);
    assign rv     = zero ? '0 : (bypass ? indata : arr_data);
    assign busy   = !zero && !bypass && arr_busy;
endmodule

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int DBG_REG  = 31
) (
    input logic        clk,
    input logic        rst,
    regfile_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int NUM_RP = 2;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic run;
    logic we_hit;
    logic iss_hit;

    // rst is synchronous, so gate combinationally to hide RUN during the reset cycle
    assign run     = (state == RUN) && !rst;
    assign we_hit  = run && bus.we_reg && (bus.rd != '0);
    assign iss_hit = run && bus.iss_valid && (bus.iss_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (cnt == LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && state == INIT)
            regs[cnt] <= '0;
        else if (we_hit)
            regs[bus.rd] <= bus.indata;
    end

    // Set beats clear: a newer producer for the same register is still outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (iss_hit && bus.iss_rd == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if (we_hit && bus.rd == ADDR_W'(i))
                    busy[i] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    logic [NUM_RP-1:0][ADDR_W-1:0] rs;
    logic [NUM_RP-1:0][DATA_W-1:0] rv;
    logic [NUM_RP-1:0]             rbusy;

    assign rs = {bus.rs2, bus.rs1};

    for (genvar p = 0; p < NUM_RP; p++) begin : g_rport
        regfile_sb_rport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rport (
            .run      (run),
            .we_hit   (we_hit),
            .rd       (bus.rd),
            .indata   (bus.indata),
            .rs       (rs[p]),
            .arr_data (regs[rs[p]]),
            .arr_busy (busy[rs[p]]),
            .rv       (rv[p]),
            .busy     (rbusy[p])
        );
    end

    assign bus.rv1      = rv[0];
    assign bus.rv2      = rv[1];
    assign bus.busy1    = rbusy[0];
    assign bus.busy2    = rbusy[1];
    assign bus.ready    = run;
    assign bus.dbg_data = run ? regs[DBG_REG] : '0;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset sweep, bypass, r0, scoreboard,
// debug port with mid-sweep reset, and writes/issues ignored during INIT.
module tb_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DBG_REG(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we_reg    = 1'b0;
        bus.rd        = '0;
        bus.indata    = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.rs1 = 5'd31;
        bus.rs2 = 5'd1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (bus.ready !== 1'b0 || bus.rv1 !== 32'h0 || bus.rv2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep edge %0d ready=%b rv1=%h rv2=%h want 0/0/0", i, bus.ready, bus.rv1, bus.rv2);
            end
            tick();
        end
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.ready);
        end
        checks++;
        if (bus.rv1 !== 32'h0 || bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_cleared rv1=%h dbg=%h want 0", bus.rv1, bus.dbg_data);
        end
    endtask

    task automatic test_bypass();
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd5;
        bus.we_reg = 1'b1;
        bus.rd = 5'd5;
        bus.indata = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.rv1 !== 32'hDEADBEEF || bus.rv2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass rv1=%h rv2=%h want deadbeef", bus.rv1, bus.rv2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rv1 !== 32'hDEADBEEF || bus.rv2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL array_read rv1=%h rv2=%h want deadbeef", bus.rv1, bus.rv2);
        end
    endtask

    task automatic test_r0();
        bus.rs1 = 5'd0;
        bus.we_reg = 1'b1;
        bus.rd = 5'd0;
        bus.indata = 32'h1234;
        #1;
        checks++;
        if (bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0) begin
            errors++;
            $display("FAIL r0_bypass rv1=%h busy1=%b want 0/0", bus.rv1, bus.busy1);
        end
        tick();
        bus.we_reg = 1'b0;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0) begin
            errors++;
            $display("FAIL r0_after rv1=%h busy1=%b want 0/0", bus.rv1, bus.busy1);
        end
    endtask

    task automatic test_scoreboard();
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd8;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd7;
        #1;
        checks++;
        if (bus.busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_before_edge busy1=%b want 0", bus.busy1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b0) begin
            errors++;
            $display("FAIL sb_set busy1=%b busy2=%b want 1/0", bus.busy1, bus.busy2);
        end
        // write and re-issue r7 in the same cycle
        bus.we_reg = 1'b1;
        bus.rd = 5'd7;
        bus.indata = 32'h77;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd7;
        #1;
        checks++;
        if (bus.busy1 !== 1'b0 || bus.rv1 !== 32'h77) begin
            errors++;
            $display("FAIL sb_bypass busy1=%b rv1=%h want 0/77", bus.busy1, bus.rv1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy1 !== 1'b1 || bus.rv1 !== 32'h77) begin
            errors++;
            $display("FAIL sb_set_wins busy1=%b rv1=%h want 1/77", bus.busy1, bus.rv1);
        end
        bus.rs2 = 5'd7;
        #1;
        checks++;
        if (bus.busy2 !== 1'b1) begin
            errors++;
            $display("FAIL sb_port2 busy2=%b want 1", bus.busy2);
        end
        bus.we_reg = 1'b1;
        bus.rd = 5'd7;
        bus.indata = 32'h78;
        tick();
        idle();
        #1;
        checks++;
        if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0 || bus.rv1 !== 32'h78) begin
            errors++;
            $display("FAIL sb_clear busy1=%b busy2=%b rv1=%h want 0/0/78", bus.busy1, bus.busy2, bus.rv1);
        end
    endtask

    task automatic test_dbg_restart();
        bus.we_reg = 1'b1;
        bus.rd = 5'd31;
        bus.indata = 32'hA5A5A5A5;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd9;
        #1;
        checks++;
        if (bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL dbg_no_bypass got %h want 0", bus.dbg_data);
        end
        tick();
        idle();
        bus.rs1 = 5'd9;
        bus.rs2 = 5'd31;
        #1;
        checks++;
        if (bus.dbg_data !== 32'hA5A5A5A5 || bus.busy1 !== 1'b1) begin
            errors++;
            $display("FAIL dbg_write dbg=%h busy1=%b want a5a5a5a5/1", bus.dbg_data, bus.busy1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.rv2 !== 32'h0 || bus.busy1 !== 1'b0 || bus.dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_run ready=%b rv2=%h busy1=%b dbg=%h want 0", bus.ready, bus.rv2, bus.busy1, bus.dbg_data);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (bus.ready !== 1'b0 || bus.dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL restart_sweep edge %0d ready=%b dbg=%h want 0/0", i, bus.ready, bus.dbg_data);
            end
            tick();
        end
        checks++;
        if (bus.ready !== 1'b1 || bus.dbg_data !== 32'h0 || bus.rv2 !== 32'h0 || bus.busy1 !== 1'b0) begin
            errors++;
            $display("FAIL restart_done ready=%b dbg=%h rv2=%h busy1=%b want 1/0/0/0", bus.ready, bus.dbg_data, bus.rv2, bus.busy1);
        end
    endtask

    task automatic test_init_ignore();
        bus.we_reg = 1'b1;
        bus.rd = 5'd3;
        bus.indata = 32'h33;
        tick();
        idle();
        bus.rs1 = 5'd3;
        #1;
        checks++;
        if (bus.rv1 !== 32'h33) begin
            errors++;
            $display("FAIL init_prewrite rv1=%h want 33", bus.rv1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.we_reg = 1'b1;
        bus.rd = 5'd3;
        bus.indata = 32'h9;
        bus.iss_valid = 1'b1;
        bus.iss_rd = 5'd3;
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0) begin
                errors++;
                $display("FAIL init_masked edge %0d rv1=%h busy1=%b want 0/0", i, bus.rv1, bus.busy1);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0) begin
            errors++;
            $display("FAIL init_ignore ready=%b rv1=%h busy1=%b want 1/0/0", bus.ready, bus.rv1, bus.busy1);
        end
    endtask

    initial begin
        bus.rs1 = '0;
        bus.rs2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_r0();
        test_scoreboard();
        test_dbg_restart();
        test_init_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
